// File: rtl/controle_varredura_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit indices,
// scan FSM state codes and the default position mask.
package pkg_display;

  localparam logic [1:0] DIG_UNID = 2'b00;
  localparam logic [1:0] DIG_APAG = 2'b01;
  localparam logic [1:0] DIG_DEZ  = 2'b10;
  localparam logic [1:0] DIG_EST  = 2'b11;

  localparam logic [1:0] APAGADO   = 2'd0;
  localparam logic [1:0] ATIVO     = 2'd1;
  localparam logic [1:0] DESLIGADO = 2'd2;

  localparam logic [3:0] MASC_PADRAO = 4'b0010;
  localparam logic [3:0] DIG_TODOS_OFF = 4'b1111;

  // Active-low enable pattern with only position idx lit.
  function automatic logic [3:0] digito_ativo(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/controle_varredura_prox_digito.sv
// Combinational finder for the next unmasked display position, scanning
// circularly upward from the position after the current one.
module prox_digito
  import pkg_display::*;
(
  input  logic [1:0] atual,
  input  logic [3:0] mascara,
  output logic [1:0] proximo,
  output logic       valido
);

  logic [1:0] cand [1:4];
  logic [3:0] livre;

  // Candidate 4 wraps back onto the current position itself.
  for (genvar gi = 1; gi <= 4; gi++) begin : g_cand
    assign cand[gi]     = atual + 2'(gi);
    assign livre[gi-1]  = ~mascara[cand[gi]];
  end

  always_comb begin
    valido = |livre;
    if (livre[0]) begin
      proximo = cand[1];
    end else if (livre[1]) begin
      proximo = cand[2];
    end else if (livre[2]) begin
      proximo = cand[3];
    end else begin
      proximo = cand[4];
    end
  end

endmodule

// File: rtl/controle_varredura.sv
// Scan controller for the 4-position multiplexed display: sequences the
// digit mux index and the active-low digit enables with a dead-time gap.
module controle_varredura
  import pkg_display::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 64,
  parameter int CW    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] mascara,
  output logic [1:0] seletor,
  output logic [3:0] digitos,
  output logic       tick_digito
);

  localparam logic [CW-1:0] FIM_ATIVO   = CW'(DIV - 1);
  localparam logic [CW-1:0] FIM_APAGADO = CW'(BLANK - 1);

  logic [1:0]    estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    dig_q, dig_d;
  logic          tick_q, tick_d;
  logic [1:0]    prox;
  logic          prox_valido;
  logic          avanca;
  logic          desliga;

  prox_digito u_prox (
    .atual   (sel_q),
    .mascara (mascara),
    .proximo (prox),
    .valido  (prox_valido)
  );

  assign desliga = ~habilita | (&mascara);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    avanca   = 1'b0;
    if (desliga) begin
      estado_d = DESLIGADO;
      cnt_d    = '0;
      if (&mascara) begin
        sel_d = DIG_UNID;
      end
    end else begin
      case (estado_q)
        DESLIGADO: begin
          estado_d = APAGADO;
          cnt_d    = '0;
          // A held position that got masked while off is skipped right away.
          if (mascara[sel_q] && prox_valido) begin
            sel_d = prox;
          end
        end
        ATIVO: begin
          if (mascara[sel_q] || (cnt_q == FIM_ATIVO)) begin
            estado_d = APAGADO;
            cnt_d    = '0;
            avanca   = 1'b1;
            if (prox_valido) begin
              sel_d = prox;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        APAGADO: begin
          if (cnt_q == FIM_APAGADO) begin
            estado_d = ATIVO;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          estado_d = APAGADO;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // Outputs are registered, so they are derived from the next state; this
  // keeps seletor changes confined to edges where every digit goes dark.
  always_comb begin
    tick_d = avanca | (sel_d != sel_q);
    dig_d  = (estado_d == ATIVO) ? digito_ativo(sel_d) : DIG_TODOS_OFF;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= APAGADO;
      cnt_q    <= '0;
      sel_q    <= DIG_UNID;
      dig_q    <= DIG_TODOS_OFF;
      tick_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end
  end

  assign seletor     = sel_q;
  assign digitos     = dig_q;
  assign tick_digito = tick_q;

endmodule

// File: tb/tb_controle_varredura.sv
// Randomized bench for controle_varredura against a cycle-level behavioural
// model of the scan rules (dead-time, lit time, masking, enable, reset).
module tb_controle_varredura;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int CW    = 4;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       habilita = 1'b1;
  logic [3:0] mascara  = 4'b0010;
  logic [1:0] seletor;
  logic [3:0] digitos;
  logic       tick_digito;

  controle_varredura #(.DIV(DIV), .BLANK(BLANK), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .mascara     (mascara),
    .seletor     (seletor),
    .digitos     (digitos),
    .tick_digito (tick_digito)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 = dark gap, 1 = lit, 2 = off.
  int         m_modo;
  int         m_cnt;
  int         m_sel;
  logic       m_tick;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int ref_prox(input int s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (!m[(s + k) % 4]) return (s + k) % 4;
    end
    return s;
  endfunction

  function automatic logic [3:0] ref_dig();
    logic [3:0] um;
    um = 4'b0001 << m_sel;
    return (m_modo == 1) ? ~um : 4'hF;
  endfunction

  task automatic model_reset();
    m_modo = 0; m_cnt = 0; m_sel = 0; m_tick = 1'b0;
  endtask

  task automatic model_edge();
    int  sel_ant;
    bit  adv;
    sel_ant = m_sel;
    adv     = 1'b0;
    if (!habilita || mascara == 4'hF) begin
      m_modo = 2; m_cnt = 0;
      if (mascara == 4'hF) m_sel = 0;
    end else if (m_modo == 2) begin
      m_modo = 0; m_cnt = 0;
      if (mascara[m_sel]) m_sel = ref_prox(m_sel, mascara);
    end else if (m_modo == 1) begin
      if (mascara[m_sel] || m_cnt == DIV - 1) begin
        m_modo = 0; m_cnt = 0; adv = 1'b1;
        m_sel = ref_prox(m_sel, mascara);
      end else begin
        m_cnt++;
      end
    end else begin
      if (m_cnt == BLANK - 1) begin
        m_modo = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_tick = adv || (m_sel != sel_ant);
  endtask

  task automatic step();
    logic [1:0] sel_ant;
    sel_ant = seletor;
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check("seletor", 8'(seletor), 8'(m_sel));
    check("digitos", 8'(digitos), 8'(ref_dig()));
    check("tick", 8'(tick_digito), 8'(m_tick));
    check("um_baixo", 8'($countones(~digitos) <= 1), 8'd1);
    if (seletor != sel_ant) check("troca_no_escuro", 8'(digitos), 8'hF);
  endtask

  task automatic espera(input string tag, input int modo, input int sel);
    int k;
    k = 0;
    while (!(m_modo == modo && (sel < 0 || m_sel == sel)) && k < 100) begin
      step();
      k++;
    end
    check(tag, 8'(m_modo == modo && (sel < 0 || m_sel == sel)), 8'd1);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_seletor", 8'(seletor), 8'h0);
    check("rst_digitos", 8'(digitos), 8'hF);
    check("rst_tick", 8'(tick_digito), 8'h0);
    repeat (2) step();
    #2 reset = 1'b1;

    // Default scan order with the blank position masked.
    repeat (40) step();

    // All four positions in turn.
    mascara = 4'b0000;
    repeat (30) step();

    // Disable while tens digit is lit, then re-enable.
    espera("espera_dez", 1, 2);
    habilita = 1'b0;
    step();
    check("off_digitos", 8'(digitos), 8'hF);
    check("off_seletor", 8'(seletor), 8'h2);
    repeat (3) step();
    habilita = 1'b1;
    repeat (2) step();
    step();
    check("religa_dez", 8'(digitos), 8'b1011);
    repeat (6) step();

    // Current position masked while lit, then everything masked.
    espera("espera_est", 1, 3);
    mascara = 4'b1010;
    step();
    check("mask_seletor", 8'(seletor), 8'h0);
    check("mask_tick", 8'(tick_digito), 8'h1);
    check("mask_digitos", 8'(digitos), 8'hF);
    repeat (5) step();
    mascara = 4'b1111;
    repeat (4) step();
    check("todas_seletor", 8'(seletor), 8'h0);
    check("todas_digitos", 8'(digitos), 8'hF);

    // Only one position left: it re-lights every period.
    mascara = 4'b1110;
    repeat (24) step();

    // Random enables and masks.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) habilita = 1'b0;
      else if (r < 15) habilita = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 5))
          0: mascara = 4'b0010;
          1: mascara = 4'b0000;
          2: mascara = 4'b1010;
          3: mascara = 4'b1110;
          4: mascara = 4'b1111;
          default: mascara = 4'($urandom_range(0, 15));
        endcase
      end
      step();
    end

    // Asynchronous reset between edges while a digit is lit.
    habilita = 1'b1;
    mascara  = 4'b0000;
    espera("espera_ativo", 1, -1);
    espera("espera_ativo_nz", 1, 2);
    #2 reset = 1'b0;
    #1;
    check("arst_digitos", 8'(digitos), 8'hF);
    check("arst_seletor", 8'(seletor), 8'h0);
    check("arst_tick", 8'(tick_digito), 8'h0);
    model_reset();
    repeat (2) step();
    #2 reset = 1'b1;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
